// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: divider FSM states and constants.
package arith_pkg;

   localparam int unsigned DIV_W = 8;

   // Quotient reported when the divisor is zero.
   localparam logic [DIV_W-1:0] DIV0_Q = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/eight_bit_seq_divider_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_W
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_q_msb,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_q_bit
);

   logic [WIDTH:0]   w_t;
   logic [WIDTH-1:0] w_diff;

   assign w_t     = {i_rem, i_q_msb};
   assign o_q_bit = (w_t >= {1'b0, i_div});
   // The restored or reduced remainder is always below the divisor, so WIDTH bits suffice.
   assign w_diff  = w_t[WIDTH-1:0] - i_div;
   assign o_rem   = o_q_bit ? w_diff : w_t[WIDTH-1:0];

endmodule

// File: rtl/eight_bit_seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
module eight_bit_seq_divider
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_q_out;
   logic [WIDTH-1:0] r_r_out;
   logic             r_dbz;
   logic             r_in_ready;
   logic             r_out_valid;

   logic             w_accept;
   logic             w_step;
   logic             w_finish;
   logic             w_b_zero;
   logic [WIDTH-1:0] w_rem_nxt;
   logic             w_q_bit;

   assign w_b_zero    = (B == '0);
   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign Q           = r_q_out;
   assign R           = r_r_out;
   assign div_by_zero = r_dbz;

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem   (r_rem),
      .i_q_msb (r_q[WIDTH-1]),
      .i_div   (r_div),
      .o_rem   (w_rem_nxt),
      .o_q_bit (w_q_bit)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and datapath strobes; CALC spends one extra cycle with count==0 to publish results.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = w_b_zero ? DONE : CALC;
            end
         end
         CALC: begin
            if (r_count == '0) begin
               w_finish    = 1'b1;
               w_state_nxt = DONE;
            end else begin
               w_step      = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Working registers and registered result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count     <= '0;
         r_rem       <= '0;
         r_q         <= '0;
         r_div       <= '0;
         r_q_out     <= '0;
         r_r_out     <= '0;
         r_dbz       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_in_ready  <= (w_state_nxt == IDLE);
         r_out_valid <= (w_state_nxt == DONE);
         if (w_accept) begin
            r_q   <= A;
            r_div <= B;
            r_rem <= '0;
            if (w_b_zero) begin
               r_q_out <= WIDTH'(DIV0_Q) | {WIDTH{1'b1}};
               r_r_out <= A;
               r_dbz   <= 1'b1;
            end else begin
               r_count <= CNT_W'(WIDTH);
            end
         end
         if (w_step) begin
            r_rem   <= w_rem_nxt;
            r_q     <= {r_q[WIDTH-2:0], w_q_bit};
            r_count <= r_count - CNT_W'(1);
         end
         if (w_finish) begin
            r_q_out <= r_q;
            r_r_out <= r_rem;
            r_dbz   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_eight_bit_seq_divider.sv
// Self-checking bench: vector table, hand-written corner sequences, random ops through a scoreboard.
module tb_eight_bit_seq_divider;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] A;
   logic [7:0] B;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] Q;
   logic [7:0] R;
   logic       div_by_zero;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
   } vec_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      int         acc;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[10];
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   rdy_mode = 0;
   bit   seen    = 0;
   exp_t h;
   int   lat;

   eight_bit_seq_divider dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .A           (A),
      .B           (B),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .Q           (Q),
      .R           (R),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Consumer: always ready, random ready, or stalled.
   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom);
         default: out_ready = 1'b0;
      endcase
   end

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic model(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r, output logic dz);
      if (b == 8'd0) begin
         q = 8'hFF; r = a; dz = 1'b1;
      end else begin
         q = a / b; r = a % b; dz = 1'b0;
      end
   endtask

   // Drive one operation; the expectation enters the scoreboard at the accepting edge.
   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] q, input logic [7:0] r, input logic dz);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1; A = a; B = b;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e = '{a, b, q, r, dz, cyc};
            sb.push_back(e);
            ok = 1'b1;
         end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready never rose for A=%0d B=%0d", a, b);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; A = 8'($urandom); B = 8'($urandom);
   endtask

   task automatic send_model(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      model(a, b, q, r, dz);
      send(a, b, q, r, dz);
   endtask

   task automatic drain();
      for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
      @(posedge clk);
   endtask

   // Result monitor: latency, values, stability under stall, invariant.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         chk("in_ready_low_in_done", int'(in_ready), 0);
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_out_valid: got out_valid=1, expected no pending result");
         end else begin
            h = sb[0];
            if (!seen) begin
               lat = cyc - h.acc - 1;
               chk("latency", lat, h.dz ? 0 : 9);
               if (!h.dz) begin
                  chk("invariant_qb_plus_r", int'(Q) * int'(h.b) + int'(R), int'(h.a));
                  chk("rem_below_div", int'(R < h.b), 1);
               end
               seen = 1'b1;
            end
            chk("quotient", int'(Q), int'(h.q));
            chk("remainder", int'(R), int'(h.r));
            chk("div_by_zero", int'(div_by_zero), int'(h.dz));
            if (out_ready) begin
               void'(sb.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
      vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
      vecs[2] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
      vecs[3] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
      vecs[4] = '{8'd100, 8'd0,   8'hFF,  8'd100, 1'b1};
      vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
      vecs[6] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};
      vecs[7] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
      vecs[8] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
      vecs[9] = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0};

      rst_n = 1'b0; in_valid = 1'b0; A = 8'd0; B = 8'd0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_q", int'(Q), 0);
      chk("reset_r", int'(R), 0);
      chk("reset_dz", int'(div_by_zero), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Vector table, consumer always ready.
      rdy_mode = 0;
      for (int i = 0; i < 10; i++) send(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
      drain();

      // Backpressure: stall in DONE, poke in_valid, then release.
      rdy_mode = 2;
      send(8'd50, 8'd7, 8'd7, 8'd1, 1'b0);
      for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
      chk("stall_out_valid", int'(out_valid), 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         in_valid = ~in_valid; A = 8'd9; B = 8'd0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      rdy_mode = 0;
      chk("no_accept_while_done", sb.size(), 1);
      drain();
      @(negedge clk);
      chk("idle_in_ready", int'(in_ready), 1);
      chk("idle_out_valid", int'(out_valid), 0);
      send(8'd77, 8'd5, 8'd15, 8'd2, 1'b0);
      drain();

      // Asynchronous reset in the middle of CALC.
      send(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midreset_in_ready", int'(in_ready), 1);
      chk("midreset_out_valid", int'(out_valid), 0);
      chk("midreset_q", int'(Q), 0);
      chk("midreset_r", int'(R), 0);
      sb.delete();
      seen = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(8'd77, 8'd3, 8'd25, 8'd2, 1'b0);
      drain();

      // Random back-to-back traffic with random consumer stalls, then a divisor sweep.
      rdy_mode = 1;
      for (int i = 0; i < 2000; i++) begin
         if (i % 4 == 0) send_model(8'($urandom), 8'($urandom_range(0, 15)));
         else            send_model(8'($urandom), 8'($urandom));
      end
      for (int b = 0; b < 256; b++) send_model(8'd255, 8'(b));
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
